uart_echo_ctrl: RTL and testbench

- Downstream consumer of the uart block's receive side. Drains bytes from the RX FIFO and holds the most recent byte for the LED bank.
- When echo is enabled, also writes each byte, XOR-masked, into the TX FIFO of the same or another uart.
- Replaces the manual debounced rd_uart button path with an autonomous FSM handshake.

---
 rtl/uart_echo_ctrl.sv | 69 ++++++
 tb/tb_uart_echo_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_ctrl.sv
// Drains the uart RX FIFO, latches the masked byte for the LEDs
// and optionally echoes it into a TX FIFO.
module uart_echo_ctrl #(
  parameter int unsigned    DBIT     = 8,
  parameter logic [DBIT-1:0] XOR_MASK = '0,
  parameter int unsigned    CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  last_byte,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             byte_tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    POP     = 2'b01,
    WAIT_TX = 2'b10,
    PUSH    = 2'b11
  } state_t;

  state_t          state;
  logic [DBIT-1:0] data_reg;

  // head word is captured before the pop so the FIFO advancing cannot race it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      data_reg  <= '0;
      last_byte <= '0;
      byte_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_empty) begin
            data_reg <= r_data ^ XOR_MASK;
            state    <= POP;
          end
        end
        POP: begin
          last_byte <= data_reg;
          byte_cnt  <= byte_cnt + CNT_W'(1);
          state     <= en ? WAIT_TX : IDLE;
        end
        WAIT_TX: begin
          if (!tx_full) state <= PUSH;
        end
        PUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // strobes come straight off the state register
  assign rd_uart   = (state == POP);
  assign byte_tick = (state == POP);
  assign wr_uart   = (state == PUSH);
  assign busy      = (state != IDLE);
  assign w_data    = data_reg;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Randomised self-checking bench for uart_echo_ctrl with a
// queue-based RX FIFO and an echo scoreboard.
module tb_uart_echo_ctrl;

  localparam logic [7:0] MASK = 8'h20;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          rx_empty = 1'b1;
  logic [7:0]    r_data = '0;
  logic          tx_full = 1'b0;
  logic          rd_uart, wr_uart, byte_tick, busy;
  logic [7:0]    w_data, last_byte;
  logic [CW-1:0] byte_cnt;

  uart_echo_ctrl #(
    .DBIT(8), .XOR_MASK(MASK), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data),
    .last_byte(last_byte), .byte_cnt(byte_cnt),
    .byte_tick(byte_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tick_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  int pop_cyc[$];
  int wr_cyc[$];

  always @(posedge clk) cyc = cyc + 1;

  // FIFO model and scoreboard: a byte is echoed iff en is high when it is popped
  always @(negedge clk) begin
    logic [7:0] b;
    if (rd_uart && rxq.size() > 0) begin
      b = rxq.pop_front();
      pop_cyc.push_back(cyc);
      if (en) exp_tx.push_back(b ^ MASK);
    end
    if (byte_tick) tick_cnt = tick_cnt + 1;
    if (wr_uart) begin
      got_tx.push_back(w_data);
      wr_cyc.push_back(cyc);
    end
    rx_empty = (rxq.size() == 0);
    r_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  task automatic clear_sb();
    exp_tx.delete();
    got_tx.delete();
    pop_cyc.delete();
    wr_cyc.delete();
    tick_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    rxq.delete();
    repeat (2) @(posedge clk);
    #1;
    clear_sb();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (!busy && rx_empty && rxq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit [7:0] exp_last;
    bit [7:0] b;
    int p;
    bit ok;
    tests++;
    if ({rd_uart, wr_uart, byte_tick, busy} !== 4'b0 ||
        w_data !== 8'h00 || last_byte !== 8'h00 || byte_cnt !== '0) begin
      fails++;
      $display("FAIL reset_init: rd=%b wr=%b tick=%b busy=%b w=%h last=%h cnt=%0d, need all 0",
               rd_uart, wr_uart, byte_tick, busy, w_data, last_byte, byte_cnt);
    end
    do_reset();
    en = 1'b1;
    tx_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      rxq.push_back(b);
      exp_last = b ^ MASK;
    end
    p = 0;
    while (!(busy && !rd_uart && pop_cyc.size() == 1) && p < 20) begin
      @(posedge clk); #1;
      p++;
    end
    tests++;
    if (p >= 20) begin
      fails++;
      $display("FAIL reset_reach_wait: pops=%0d busy=%b, need WAIT_TX", pop_cyc.size(), busy);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({rd_uart, wr_uart, byte_tick, busy} !== 4'b0 ||
        w_data !== 8'h00 || last_byte !== 8'h00 || byte_cnt !== '0) begin
      fails++;
      $display("FAIL reset_async: rd=%b wr=%b tick=%b busy=%b w=%h last=%h cnt=%0d, need all 0",
               rd_uart, wr_uart, byte_tick, busy, w_data, last_byte, byte_cnt);
    end
    @(posedge clk); #1;
    clear_sb();
    en = 1'b0;
    tx_full = 1'b0;
    reset = 1'b0;
    wait_done(40, ok);
    tests++;
    if (!ok || pop_cyc.size() != 2 || byte_cnt !== CW'(2) ||
        last_byte !== exp_last || got_tx.size() != 0) begin
      fails++;
      $display("FAIL reset_drain: ok=%0d pops=%0d cnt=%0d last=%h wr=%0d, need 1/2/2/%h/0",
               ok, pop_cyc.size(), byte_cnt, last_byte, got_tx.size(), exp_last);
    end
  endtask

  task automatic test_drain();
    int p;
    bit ok;
    do_reset();
    en = 1'b0;
    tx_full = 1'b0;
    @(posedge clk); #1;
    rxq.push_back(8'hA5);
    p = cyc;
    wait_done(20, ok);
    tests++;
    if (!ok || pop_cyc.size() != 1 || (pop_cyc.size() == 1 && pop_cyc[0] != p + 1)) begin
      fails++;
      $display("FAIL drain_pop: ok=%0d pops=%0d first=%0d, need one pop at %0d",
               ok, pop_cyc.size(), pop_cyc.size() ? pop_cyc[0] : -1, p + 1);
    end
    tests++;
    if (last_byte !== (8'hA5 ^ MASK) || byte_cnt !== CW'(1) ||
        tick_cnt != 1 || got_tx.size() != 0) begin
      fails++;
      $display("FAIL drain_state: last=%h cnt=%0d ticks=%0d wr=%0d, need %h/1/1/0",
               last_byte, byte_cnt, tick_cnt, got_tx.size(), 8'hA5 ^ MASK);
    end
    clear_sb();
    for (int i = 0; i < 5; i++) rxq.push_back(8'($urandom));
    wait_done(40, ok);
    tests++;
    if (!ok || pop_cyc.size() != 5 || pop_cyc[4] - pop_cyc[0] != 8 || got_tx.size() != 0) begin
      fails++;
      $display("FAIL drain_rate: ok=%0d pops=%0d span=%0d wr=%0d, need 5 pops span 8 no wr",
               ok, pop_cyc.size(), pop_cyc.size() == 5 ? pop_cyc[4] - pop_cyc[0] : -1,
               got_tx.size());
    end
  endtask

  task automatic test_echo();
    int p;
    bit ok;
    do_reset();
    en = 1'b1;
    tx_full = 1'b0;
    @(posedge clk); #1;
    rxq.push_back(8'h41);
    rxq.push_back(8'h42);
    p = cyc;
    wait_done(40, ok);
    tests++;
    if (!ok || got_tx.size() != 2 || got_tx[0] !== 8'h61 || got_tx[1] !== 8'h62) begin
      fails++;
      $display("FAIL echo_data: ok=%0d n=%0d d0=%h d1=%h, need 61 62",
               ok, got_tx.size(), got_tx.size() > 0 ? got_tx[0] : 8'hxx,
               got_tx.size() > 1 ? got_tx[1] : 8'hxx);
    end
    tests++;
    if (wr_cyc.size() != 2 || wr_cyc[0] != p + 3 || wr_cyc[1] != p + 7) begin
      fails++;
      $display("FAIL echo_timing: n=%0d w0=%0d w1=%0d, need %0d %0d",
               wr_cyc.size(), wr_cyc.size() > 0 ? wr_cyc[0] : -1,
               wr_cyc.size() > 1 ? wr_cyc[1] : -1, p + 3, p + 7);
    end
    tests++;
    if (byte_cnt !== CW'(2) || last_byte !== 8'h62) begin
      fails++;
      $display("FAIL echo_state: cnt=%0d last=%h, need 2 62", byte_cnt, last_byte);
    end
  endtask

  task automatic test_backpressure();
    int bad_busy;
    bit ok;
    do_reset();
    en = 1'b1;
    tx_full = 1'b1;
    for (int i = 0; i < 3; i++) rxq.push_back(8'($urandom));
    repeat (2) @(posedge clk);
    bad_busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!busy) bad_busy++;
    end
    tests++;
    if (pop_cyc.size() != 1 || got_tx.size() != 0 || bad_busy != 0) begin
      fails++;
      $display("FAIL bp_stall: pops=%0d wr=%0d idle_cycles=%0d, need 1/0/0",
               pop_cyc.size(), got_tx.size(), bad_busy);
    end
    tx_full = 1'b0;
    wait_done(60, ok);
    tests++;
    if (!ok || got_tx.size() != 3 || got_tx != exp_tx) begin
      fails++;
      $display("FAIL bp_release: ok=%0d got=%p need=%p", ok, got_tx, exp_tx);
    end
  endtask

  task automatic test_wrap_en();
    logic [7:0] src[$];
    logic [7:0] want[$];
    int p;
    bit ok;
    do_reset();
    en = 1'b1;
    tx_full = 1'b0;
    for (int i = 0; i < 17; i++) begin
      src.push_back(8'($urandom));
      rxq.push_back(src[i]);
    end
    for (int i = 0; i < 5; i++) want.push_back(src[i] ^ MASK);
    p = 0;
    while (!(busy && !rd_uart && !wr_uart && pop_cyc.size() == 5) && p < 60) begin
      @(posedge clk); #1;
      p++;
    end
    en = 1'b0;
    wait_done(80, ok);
    tests++;
    if (p >= 60 || !ok || got_tx != want) begin
      fails++;
      $display("FAIL wrap_echo: reached=%0d ok=%0d got=%p need=%p", p < 60, ok, got_tx, want);
    end
    tests++;
    if (byte_cnt !== CW'(1) || last_byte !== (src[16] ^ MASK) || pop_cyc.size() != 17) begin
      fails++;
      $display("FAIL wrap_cnt: cnt=%0d last=%h pops=%0d, need 1 %h 17",
               byte_cnt, last_byte, pop_cyc.size(), src[16] ^ MASK);
    end
  endtask

  task automatic test_random();
    logic [7:0] b, exp_last;
    int sent;
    bit ok;
    do_reset();
    sent = 0;
    exp_last = 8'h00;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      en = 1'($urandom);
      tx_full = ($urandom_range(0, 3) == 0);
      if (sent < 40 && $urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        rxq.push_back(b);
        exp_last = b ^ MASK;
        sent++;
      end
    end
    tx_full = 1'b0;
    wait_done(400, ok);
    tests++;
    if (!ok || got_tx != exp_tx) begin
      fails++;
      $display("FAIL rand_echo: ok=%0d got_n=%0d need_n=%0d", ok, got_tx.size(), exp_tx.size());
    end
    tests++;
    if (byte_cnt !== CW'(sent) || last_byte !== exp_last || tick_cnt != sent) begin
      fails++;
      $display("FAIL rand_state: cnt=%0d last=%h ticks=%0d, need %0d %h %0d",
               byte_cnt, last_byte, tick_cnt, sent % 16, exp_last, sent);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_drain();
    test_echo();
    test_backpressure();
    test_wrap_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
